key_mode_ctrl: RTL and testbench
================================

KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: the number of consecutive cycles a synchronised key level must hold before it is accepted; legal range 1 or more.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 8: the cycles from the first up/down event to the first auto-repeat event.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 2: the cycles between subsequent auto-repeat events.
REQ-004 The block SHALL have parameter IDLE_TIMEOUT, default 64: the cycles without a key event after which a set mode returns to RUN.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous, active-high.
REQ-007 The block SHALL have ports key_mode, key_sel, key_up and key_down, each input, 1 bit: raw push-buttons, active-high, asynchronous to clk.
REQ-008 The block SHALL have port alarming, input, 1 bit: high while the alarm is sounding.
REQ-009 The block SHALL have port mode, output, 2 bits: 0 = RUN, 1 = SET_TIME, 2 = SET_ALARM.
REQ-010 The block SHALL have port field_sel, output, 3 bits: one-hot field select; bit0 = second, bit1 = minute, bit2 = hour.
REQ-011 The block SHALL have ports time_inc and time_dec, each output, 3 bits: one-cycle per-field step pulses to the time counter.
REQ-012 The block SHALL have ports alarm_inc and alarm_dec, each output, 3 bits: one-cycle per-field step pulses to the alarm compare (signal_increase/signal_decrease).
REQ-013 The block SHALL have port alarm_en, output, 1 bit: alarm enable level.
REQ-014 The block SHALL have port dis_alarm, output, 1 bit: one-cycle alarm-silence pulse.

Function
REQ-015 Each raw key SHALL pass through a 2-flop synchroniser.
REQ-016 Each key's debounced level SHALL change only after its synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreement in between SHALL restart that count.
REQ-017 A press event SHALL be a debounced 0->1 transition.
REQ-018 Every output SHALL be registered; the action for a press SHALL appear DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw key high.
REQ-019 While key_up or key_down stays debounced-high, a repeat event SHALL occur REPEAT_DELAY cycles after the first event and then every REPEAT_RATE cycles; release SHALL stop repeats immediately.
REQ-020 When several events occur in the same cycle, exactly one SHALL be acted on, with priority silence > mode > sel > up > down; the others SHALL be discarded.
REQ-021 Silence: any press event (not a repeat) while alarming = 1 SHALL produce dis_alarm = 1 for one cycle and no other action.
REQ-022 The mode FSM SHALL step RUN -> SET_TIME -> SET_ALARM -> RUN on each mode event.
REQ-023 Entering SET_TIME or SET_ALARM SHALL set field_sel to 001.
REQ-024 A sel event in a set mode SHALL rotate field_sel 001 -> 010 -> 100 -> 001.
REQ-025 A sel event in RUN SHALL toggle alarm_en and leave field_sel unchanged.
REQ-026 An up event SHALL pulse field_sel on time_inc in SET_TIME, or on alarm_inc in SET_ALARM; a down event SHALL do the same on time_dec or alarm_dec.
REQ-027 Up and down events in RUN SHALL have no effect.
REQ-028 At most one bit of the four step buses SHALL be high in any cycle, for exactly one cycle.
REQ-029 An idle counter SHALL clear on every acted-on event and count in a set mode; on reaching IDLE_TIMEOUT, mode SHALL become RUN and the counter SHALL clear.
REQ-030 A repeat event SHALL count as activity for the idle counter.

Reset
REQ-031 Reset SHALL set mode = RUN, field_sel = 001, alarm_en = 0, dis_alarm = 0 and all step buses = 0.
REQ-032 Reset SHALL clear all synchronisers, debounced levels, debounce, repeat and idle counters to 0.
REQ-033 A key held through reset deassertion SHALL be treated as a fresh press and generate one event after DEBOUNCE_CYCLES+3 cycles.
REQ-034 Reset asserted mid-repeat or mid-timeout SHALL abort that activity with no further pulses.

Verification
REQ-035 Defaults; key_mode held high for 20 cycles -> mode = 1 at edge 7, field_sel = 001, exactly one mode step.
REQ-036 In SET_TIME, key_up held for 20 cycles from edge 0 -> time_inc = 001 at edges 7, 15, 17, 19 and 21; no alarm_inc pulses.
REQ-037 key_up bouncing 1-high/1-low for 10 cycles, then low -> no pulses on any output.
REQ-038 RUN with alarming = 1, key_sel pressed -> dis_alarm pulses once; alarm_en unchanged. Repeating with alarming = 0 -> alarm_en toggles 0 -> 1.
REQ-039 SET_ALARM, sel pressed twice, then no keys -> field_sel = 100, then mode = 0 exactly 64 cycles after the last event.
REQ-040 key_up and key_down rising on the same cycle in SET_TIME -> time_inc only; rst pulsed during repeat -> all outputs at reset values, no further pulses.

Source files
------------

// File: rtl/key_mode_ctrl.sv
// Push-button front end for a clock: synchronise and debounce four keys, auto-repeat up/down,
// and drive the RUN/SET_TIME/SET_ALARM mode FSM, field select and one-cycle step pulses.
module key_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 2,
  parameter int IDLE_TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       alarming,
  output logic [1:0] mode,
  output logic [2:0] field_sel,
  output logic [2:0] time_inc,
  output logic [2:0] time_dec,
  output logic [2:0] alarm_inc,
  output logic [2:0] alarm_dec,
  output logic       alarm_en,
  output logic       dis_alarm
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} mode_e;

  localparam int CW = 16;

  // key index: 0 = mode, 1 = sel, 2 = up, 3 = down
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]    deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CW-1:0] db_cnt_q [4];
  logic [CW-1:0] db_cnt_d [4];
  logic [CW-1:0] rpt_cnt_q [2];
  logic [CW-1:0] rpt_cnt_d [2];
  logic [1:0]    rpt_first_q, rpt_first_d;
  logic [3:0]    press;
  logic [1:0]    rep;
  logic [4:0]    evt_q, evt_d;
  mode_e         mode_q, mode_d;
  logic [2:0]    field_sel_q, field_sel_d;
  logic [2:0]    time_inc_q, time_inc_d, time_dec_q, time_dec_d;
  logic [2:0]    alarm_inc_q, alarm_inc_d, alarm_dec_q, alarm_dec_d;
  logic          alarm_en_q, alarm_en_d, dis_alarm_q, dis_alarm_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          acted;

  assign raw = {key_down, key_up, key_sel, key_mode};

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
    press = deb_q & ~deb_prev_q;
  end

  // Repeats run only while both the debounced and synchronised levels are high, so a release
  // stops them before the debounced level has caught up. A zero count means "not armed".
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rep[j]         = 1'b0;
      rpt_cnt_d[j]   = rpt_cnt_q[j];
      rpt_first_d[j] = rpt_first_q[j];
      if (press[j+2]) begin
        rpt_cnt_d[j]   = CW'(1);
        rpt_first_d[j] = 1'b1;
      end else if (deb_q[j+2] && sync2_q[j+2] && rpt_cnt_q[j] != '0) begin
        if ((rpt_first_q[j] && rpt_cnt_q[j] == CW'(REPEAT_DELAY)) ||
            (!rpt_first_q[j] && rpt_cnt_q[j] == CW'(REPEAT_RATE))) begin
          rep[j]         = 1'b1;
          rpt_cnt_d[j]   = CW'(1);
          rpt_first_d[j] = 1'b0;
        end else begin
          rpt_cnt_d[j] = rpt_cnt_q[j] + CW'(1);
        end
      end else begin
        rpt_cnt_d[j]   = '0;
        rpt_first_d[j] = 1'b0;
      end
    end
    if (|press && alarming) begin
      evt_d = 5'b10000;
    end else begin
      evt_d = {1'b0, press[0], press[1], press[2] | rep[0], press[3] | rep[1]};
    end
  end

  always_comb begin
    mode_d      = mode_q;
    field_sel_d = field_sel_q;
    alarm_en_d  = alarm_en_q;
    dis_alarm_d = 1'b0;
    time_inc_d  = '0;
    time_dec_d  = '0;
    alarm_inc_d = '0;
    alarm_dec_d = '0;
    idle_cnt_d  = '0;
    acted       = 1'b1;
    if (evt_q[4]) begin
      dis_alarm_d = 1'b1;
    end else if (evt_q[3]) begin
      case (mode_q)
        RUN:      mode_d = SET_TIME;
        SET_TIME: mode_d = SET_ALARM;
        default:  mode_d = RUN;
      endcase
      if (mode_q != SET_ALARM) field_sel_d = 3'b001;
    end else if (evt_q[2]) begin
      if (mode_q == RUN) alarm_en_d = ~alarm_en_q;
      else field_sel_d = {field_sel_q[1:0], field_sel_q[2]};
    end else if (evt_q[1]) begin
      if (mode_q == SET_TIME) time_inc_d = field_sel_q;
      else if (mode_q == SET_ALARM) alarm_inc_d = field_sel_q;
    end else if (evt_q[0]) begin
      if (mode_q == SET_TIME) time_dec_d = field_sel_q;
      else if (mode_q == SET_ALARM) alarm_dec_d = field_sel_q;
    end else begin
      acted = 1'b0;
    end
    if (!acted && mode_q != RUN) begin
      if (idle_cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
        mode_d = RUN;
      end else begin
        idle_cnt_d = idle_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      for (int j = 0; j < 2; j++) rpt_cnt_q[j] <= '0;
      rpt_first_q <= '0;
      evt_q       <= '0;
      mode_q      <= RUN;
      field_sel_q <= 3'b001;
      time_inc_q  <= '0;
      time_dec_q  <= '0;
      alarm_inc_q <= '0;
      alarm_dec_q <= '0;
      alarm_en_q  <= 1'b0;
      dis_alarm_q <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int j = 0; j < 2; j++) rpt_cnt_q[j] <= rpt_cnt_d[j];
      rpt_first_q <= rpt_first_d;
      evt_q       <= evt_d;
      mode_q      <= mode_d;
      field_sel_q <= field_sel_d;
      time_inc_q  <= time_inc_d;
      time_dec_q  <= time_dec_d;
      alarm_inc_q <= alarm_inc_d;
      alarm_dec_q <= alarm_dec_d;
      alarm_en_q  <= alarm_en_d;
      dis_alarm_q <= dis_alarm_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign mode      = mode_q;
  assign field_sel = field_sel_q;
  assign time_inc  = time_inc_q;
  assign time_dec  = time_dec_q;
  assign alarm_inc = alarm_inc_q;
  assign alarm_dec = alarm_dec_q;
  assign alarm_en  = alarm_en_q;
  assign dis_alarm = dis_alarm_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl: edge e means the e-th rising edge after a key is driven,
// outputs are sampled on the falling edge that follows it.
module tb_key_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0, key_sel = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic       alarming = 1'b0;
  logic [1:0] mode;
  logic [2:0] field_sel, time_inc, time_dec, alarm_inc, alarm_dec;
  logic       alarm_en, dis_alarm;

  int n_cmp = 0;
  int n_bad = 0;
  int c_ti, c_td, c_ai, c_ad, c_dis, c_multi;

  always #5 clk = ~clk;

  key_mode_ctrl dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_sel(key_sel), .key_up(key_up), .key_down(key_down),
    .alarming(alarming),
    .mode(mode), .field_sel(field_sel),
    .time_inc(time_inc), .time_dec(time_dec),
    .alarm_inc(alarm_inc), .alarm_dec(alarm_dec),
    .alarm_en(alarm_en), .dis_alarm(dis_alarm)
  );

  task automatic clear_counts();
    c_ti = 0; c_td = 0; c_ai = 0; c_ad = 0; c_dis = 0; c_multi = 0;
  endtask

  task automatic sample_counts();
    c_ti  += (time_inc  != 3'b000) ? 1 : 0;
    c_td  += (time_dec  != 3'b000) ? 1 : 0;
    c_ai  += (alarm_inc != 3'b000) ? 1 : 0;
    c_ad  += (alarm_dec != 3'b000) ? 1 : 0;
    c_dis += dis_alarm ? 1 : 0;
    c_multi += ($countones({time_inc, time_dec, alarm_inc, alarm_dec}) > 1) ? 1 : 0;
  endtask

  task automatic set_key(input int idx, input logic v);
    case (idx)
      0: key_mode = v;
      1: key_sel  = v;
      2: key_up   = v;
      default: key_down = v;
    endcase
  endtask

  // Raw key high for `hold` sampling edges, then low long enough to debounce the release.
  task automatic press_key(input int idx, input int hold);
    set_key(idx, 1'b1);
    for (int i = 0; i < hold + 14; i++) begin
      @(negedge clk);
      sample_counts();
      if (i == hold - 1) set_key(idx, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    key_mode = 0; key_sel = 0; key_up = 0; key_down = 0; alarming = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode got %0d want 0", mode); end
    n_cmp++; if (field_sel !== 3'b001) begin n_bad++; $display("FAIL reset_field got %b want 001", field_sel); end
    n_cmp++; if (alarm_en !== 1'b0) begin n_bad++; $display("FAIL reset_alarm_en got %b want 0", alarm_en); end
    n_cmp++; if (dis_alarm !== 1'b0) begin n_bad++; $display("FAIL reset_dis got %b want 0", dis_alarm); end
    n_cmp++; if ({time_inc, time_dec, alarm_inc, alarm_dec} !== 12'h000) begin
      n_bad++; $display("FAIL reset_steps got %h want 000", {time_inc, time_dec, alarm_inc, alarm_dec});
    end
    do_reset();
  endtask

  task automatic test_mode_hold();
    logic [1:0] prev;
    int steps;
    do_reset();
    steps = 0;
    prev = mode;
    key_mode = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (mode !== prev) steps++;
      prev = mode;
      n_cmp++;
      if (mode !== ((e >= 7) ? 2'd1 : 2'd0)) begin
        n_bad++; $display("FAIL mode_hold edge %0d got %0d want %0d", e, mode, (e >= 7) ? 1 : 0);
      end
      if (e == 19) key_mode = 1'b0;
    end
    n_cmp++; if (field_sel !== 3'b001) begin n_bad++; $display("FAIL mode_hold_field got %b want 001", field_sel); end
    n_cmp++; if (steps != 1) begin n_bad++; $display("FAIL mode_hold_steps got %0d want 1", steps); end
  endtask

  task automatic test_up_repeat();
    logic [2:0] exp;
    do_reset();
    press_key(0, 6);
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL up_rpt_setup mode got %0d want 1", mode); end
    clear_counts();
    key_up = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      sample_counts();
      exp = (e == 7 || e == 15 || e == 17 || e == 19 || e == 21) ? 3'b001 : 3'b000;
      n_cmp++;
      if (time_inc !== exp) begin n_bad++; $display("FAIL up_rpt edge %0d got %b want %b", e, time_inc, exp); end
      if (e == 19) key_up = 1'b0;
    end
    n_cmp++; if (c_ti != 5) begin n_bad++; $display("FAIL up_rpt_count got %0d want 5", c_ti); end
    n_cmp++; if (c_ai != 0) begin n_bad++; $display("FAIL up_rpt_alarm_inc got %0d want 0", c_ai); end
    n_cmp++; if (c_multi != 0) begin n_bad++; $display("FAIL up_rpt_onehot got %0d want 0", c_multi); end
  endtask

  task automatic test_bounce();
    do_reset();
    press_key(0, 6);
    clear_counts();
    key_up = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      sample_counts();
      key_up = (e < 9) ? ~key_up : 1'b0;
    end
    n_cmp++;
    if (c_ti + c_td + c_ai + c_ad + c_dis != 0) begin
      n_bad++; $display("FAIL bounce_pulses got %0d want 0", c_ti + c_td + c_ai + c_ad + c_dis);
    end
    n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL bounce_mode got %0d want 1", mode); end
  endtask

  task automatic test_silence();
    do_reset();
    alarming = 1'b1;
    clear_counts();
    press_key(1, 6);
    n_cmp++; if (c_dis != 1) begin n_bad++; $display("FAIL silence_pulse got %0d want 1", c_dis); end
    n_cmp++; if (alarm_en !== 1'b0) begin n_bad++; $display("FAIL silence_alarm_en got %b want 0", alarm_en); end
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL silence_mode got %0d want 0", mode); end
    alarming = 1'b0;
    clear_counts();
    press_key(1, 6);
    n_cmp++; if (alarm_en !== 1'b1) begin n_bad++; $display("FAIL sel_run_alarm_en got %b want 1", alarm_en); end
    n_cmp++; if (c_dis != 0) begin n_bad++; $display("FAIL sel_run_dis got %0d want 0", c_dis); end
    n_cmp++; if (field_sel !== 3'b001) begin n_bad++; $display("FAIL sel_run_field got %b want 001", field_sel); end
  endtask

  task automatic test_idle_timeout();
    do_reset();
    press_key(0, 6);
    press_key(0, 6);
    n_cmp++; if (mode !== 2'd2) begin n_bad++; $display("FAIL idle_setup mode got %0d want 2", mode); end
    clear_counts();
    press_key(3, 6);
    n_cmp++; if (c_ad != 1 || c_td != 0) begin
      n_bad++; $display("FAIL alarm_dec count got %0d/%0d want 1/0", c_ad, c_td);
    end
    press_key(1, 6);
    n_cmp++; if (field_sel !== 3'b010) begin n_bad++; $display("FAIL idle_sel1 got %b want 010", field_sel); end
    key_sel = 1'b1;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      if (e == 5) key_sel = 1'b0;
      if (e == 7) begin
        n_cmp++; if (field_sel !== 3'b100) begin n_bad++; $display("FAIL idle_sel2 got %b want 100", field_sel); end
      end
      if (e == 70) begin
        n_cmp++; if (mode !== 2'd2) begin n_bad++; $display("FAIL idle_before got %0d want 2", mode); end
      end
      if (e == 71) begin
        n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL idle_after got %0d want 0", mode); end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    do_reset();
    press_key(0, 6);
    clear_counts();
    key_up = 1'b1;
    key_down = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      sample_counts();
      if (e == 5) begin key_up = 1'b0; key_down = 1'b0; end
      exp = (e == 7) ? 3'b001 : 3'b000;
      n_cmp++;
      if (time_inc !== exp) begin n_bad++; $display("FAIL simul_inc edge %0d got %b want %b", e, time_inc, exp); end
    end
    n_cmp++; if (c_td != 0) begin n_bad++; $display("FAIL simul_dec got %0d want 0", c_td); end
  endtask

  task automatic test_reset_mid_repeat();
    do_reset();
    press_key(0, 6);
    clear_counts();
    key_up = 1'b1;
    for (int e = 0; e < 17; e++) begin
      @(negedge clk);
      sample_counts();
    end
    rst = 1'b1;
    key_up = 1'b0;
    #1;
    n_cmp++; if (c_ti != 2) begin n_bad++; $display("FAIL midrpt_before got %0d want 2", c_ti); end
    n_cmp++; if (mode !== 2'd0 || field_sel !== 3'b001 || time_inc !== 3'b000) begin
      n_bad++; $display("FAIL midrpt_reset got mode %0d field %b inc %b want 0/001/000", mode, field_sel, time_inc);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_counts();
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      sample_counts();
    end
    n_cmp++; if (c_ti + c_td + c_ai + c_ad + c_dis != 0) begin
      n_bad++; $display("FAIL midrpt_after got %0d want 0", c_ti + c_td + c_ai + c_ad + c_dis);
    end
    n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL midrpt_mode got %0d want 0", mode); end
  endtask

  task automatic test_held_through_reset();
    @(negedge clk);
    rst = 1'b1;
    key_mode = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      n_cmp++;
      if (mode !== ((e >= 7) ? 2'd1 : 2'd0)) begin
        n_bad++; $display("FAIL held_rst edge %0d got %0d want %0d", e, mode, (e >= 7) ? 1 : 0);
      end
    end
    key_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode_hold();
    test_up_repeat();
    test_bounce();
    test_silence();
    test_idle_timeout();
    test_simultaneous();
    test_reset_mid_repeat();
    test_held_through_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
